// File: rtl/ctrl_pipe_pkg.sv
// Control-bundle types shared by the decoder and the ID/EX/MEM/WB control pipeline.
// Each stage slice is kept as its own struct so stage registers carry only what is still needed.
package ctrl_pipe_pkg;

    typedef enum logic [3:0] {
        ALUOP_ADD = 4'd0,
        ALUOP_SUB = 4'd1,
        ALUOP_AND = 4'd2,
        ALUOP_OR  = 4'd3,
        ALUOP_XOR = 4'd4,
        ALUOP_SLT = 4'd5,
        ALUOP_SLL = 4'd6,
        ALUOP_SRL = 4'd7
    } aluctrl_t;

    typedef enum logic {
        ALUSRC_IMM = 1'b0,
        ALUSRC_REG = 1'b1
    } alusrc_t;

    typedef struct packed {
        aluctrl_t aluop;
        alusrc_t  alusrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic is_branch;
        logic mem_re;
        logic mem_we;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_wr_en;
        logic is_mem_to_reg;
    } wb_ctrl_t;

    // q2_bits is the ID-stage slice: set for JAL, which redirects from ID.
    typedef struct packed {
        logic      q2_bits;
        ex_ctrl_t  q3;
        mem_ctrl_t q4;
        wb_ctrl_t  q5;
    } cpu_ctrl_t;

    localparam ex_ctrl_t  CTRL_BUBBLE_EX  = '{aluop: ALUOP_ADD, alusrc: ALUSRC_IMM};
    localparam mem_ctrl_t CTRL_BUBBLE_MEM = '0;
    localparam wb_ctrl_t  CTRL_BUBBLE_WB  = '0;

endpackage

// File: rtl/ctrl_hazard.sv
// Load-use compare between the instruction in ID and a load sitting in EX.
// Purely combinational; all pipeline state lives in ctrl_pipe.
module ctrl_hazard #(
    parameter int REG_ADDR_W = 5,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_re,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    output logic                  o_load_use
);

    generate
        if (HAZARD_EN != 0) begin : g_detect
            // x0 is hard-wired zero, so a load targeting it never produces a dependency.
            assign o_load_use = i_id_valid & i_ex_valid & i_ex_mem_re
                              & (i_ex_rd != '0)
                              & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));
        end else begin : g_off
            assign o_load_use = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded control from ID through the EX, MEM and WB stage registers,
// with load-use stalling, branch/jump squashing and a saturating stall counter.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int HAZARD_EN  = 1,
    parameter int PERF_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_id_valid,
    input  cpu_ctrl_t             i_id_ctrl,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_mem_branch_taken,
    input  logic                  i_mem_jalr,
    output logic                  o_stall,
    output logic                  o_flush_ifid,
    output logic                  o_id_jal,
    output logic                  o_ex_valid,
    output aluctrl_t              o_ex_aluop,
    output alusrc_t               o_ex_alusrc,
    output logic [REG_ADDR_W-1:0] o_ex_rd,
    output logic                  o_mem_valid,
    output logic                  o_mem_is_branch,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [REG_ADDR_W-1:0] o_mem_rd,
    output logic                  o_wb_reg_wr_en,
    output logic                  o_wb_is_mem_to_reg,
    output logic [REG_ADDR_W-1:0] o_wb_rd,
    output logic [PERF_W-1:0]     o_stall_cnt
);

    logic                  ex_valid_q, ex_valid_d;
    ex_ctrl_t              ex_ctrl_q, ex_ctrl_d;
    mem_ctrl_t             ex_mem_q, ex_mem_d;
    wb_ctrl_t              ex_wb_q, ex_wb_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

    logic                  mem_valid_q, mem_valid_d;
    mem_ctrl_t             mem_ctrl_q, mem_ctrl_d;
    wb_ctrl_t              mem_wb_q, mem_wb_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;

    wb_ctrl_t              wb_ctrl_q, wb_ctrl_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;

    logic [PERF_W-1:0]     stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic redirect;
    logic stall;
    logic id_advance;

    ctrl_hazard #(
        .REG_ADDR_W (REG_ADDR_W),
        .HAZARD_EN  (HAZARD_EN)
    ) u_hazard (
        .i_id_valid  (i_id_valid),
        .i_id_rs1    (i_id_rs1),
        .i_id_rs2    (i_id_rs2),
        .i_ex_valid  (ex_valid_q),
        .i_ex_mem_re (ex_mem_q.mem_re),
        .i_ex_rd     (ex_rd_q),
        .o_load_use  (load_use)
    );

    // Redirect outranks the hazard: the stalled instruction is on the wrong path anyway.
    always_comb begin
        redirect   = mem_valid_q & ((mem_ctrl_q.is_branch & i_mem_branch_taken) | i_mem_jalr);
        stall      = load_use & ~redirect;
        id_advance = i_id_valid & ~stall & ~redirect;
    end

    always_comb begin
        ex_valid_d  = 1'b0;
        ex_ctrl_d   = CTRL_BUBBLE_EX;
        ex_mem_d    = CTRL_BUBBLE_MEM;
        ex_wb_d     = CTRL_BUBBLE_WB;
        ex_rd_d     = '0;
        mem_valid_d = 1'b0;
        mem_ctrl_d  = CTRL_BUBBLE_MEM;
        mem_wb_d    = CTRL_BUBBLE_WB;
        mem_rd_d    = '0;
        stall_cnt_d = stall_cnt_q;

        if (id_advance) begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = i_id_ctrl.q3;
            ex_mem_d   = i_id_ctrl.q4;
            ex_wb_d    = i_id_ctrl.q5;
            ex_rd_d    = i_id_rd;
        end

        if (ex_valid_q && !redirect) begin
            mem_valid_d = 1'b1;
            mem_ctrl_d  = ex_mem_q;
            mem_wb_d    = ex_wb_q;
            mem_rd_d    = ex_rd_q;
        end

        // MEM has already resolved, so it always retires regardless of redirect.
        wb_ctrl_d = mem_wb_q;
        wb_rd_d   = mem_rd_q;

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_BUBBLE_EX;
            ex_mem_q    <= CTRL_BUBBLE_MEM;
            ex_wb_q     <= CTRL_BUBBLE_WB;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= CTRL_BUBBLE_MEM;
            mem_wb_q    <= CTRL_BUBBLE_WB;
            mem_rd_q    <= '0;
            wb_ctrl_q   <= CTRL_BUBBLE_WB;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_mem_q    <= ex_mem_d;
            ex_wb_q     <= ex_wb_d;
            ex_rd_q     <= ex_rd_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_wb_q    <= mem_wb_d;
            mem_rd_q    <= mem_rd_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        o_stall            = stall;
        o_id_jal           = id_advance & i_id_ctrl.q2_bits;
        o_flush_ifid       = redirect | o_id_jal;
        o_ex_valid         = ex_valid_q;
        o_ex_aluop         = ex_ctrl_q.aluop;
        o_ex_alusrc        = ex_ctrl_q.alusrc;
        o_ex_rd            = ex_rd_q;
        o_mem_valid        = mem_valid_q;
        o_mem_is_branch    = mem_ctrl_q.is_branch;
        o_mem_re           = mem_ctrl_q.mem_re;
        o_mem_we           = mem_ctrl_q.mem_we;
        o_mem_rd           = mem_rd_q;
        o_wb_reg_wr_en     = wb_ctrl_q.reg_wr_en;
        o_wb_is_mem_to_reg = wb_ctrl_q.is_mem_to_reg;
        o_wb_rd            = wb_rd_q;
        o_stall_cnt        = stall_cnt_q;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and random checks of ctrl_pipe against an instruction-level pipeline model.
// The model tracks whole decoded instructions per stage and applies bubble gating when comparing.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    localparam int AW = 5;
    localparam int PW = 2;

    logic            clk;
    logic            rst;
    logic            idValid;
    cpu_ctrl_t       idCtrl;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            taken, jalr;

    logic            oStall, oFlush, oJal;
    logic            oExValid;
    aluctrl_t        oExAluop;
    alusrc_t         oExAlusrc;
    logic [AW-1:0]   oExRd;
    logic            oMemValid, oMemBranch, oMemRe, oMemWe;
    logic [AW-1:0]   oMemRd;
    logic            oWbWr, oWbM2r;
    logic [AW-1:0]   oWbRd;
    logic [PW-1:0]   oCnt;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        bit            valid;
        cpu_ctrl_t     ctrl;
        logic [AW-1:0] rd;
    } instr_t;

    instr_t mEx, mMem, mWb;
    int     mCnt;
    bit     mRedirect, mStall, mJal;

    ctrl_pipe #(.REG_ADDR_W(AW), .HAZARD_EN(1), .PERF_W(PW)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_id_valid         (idValid),
        .i_id_ctrl          (idCtrl),
        .i_id_rs1           (rs1),
        .i_id_rs2           (rs2),
        .i_id_rd            (rd),
        .i_mem_branch_taken (taken),
        .i_mem_jalr         (jalr),
        .o_stall            (oStall),
        .o_flush_ifid       (oFlush),
        .o_id_jal           (oJal),
        .o_ex_valid         (oExValid),
        .o_ex_aluop         (oExAluop),
        .o_ex_alusrc        (oExAlusrc),
        .o_ex_rd            (oExRd),
        .o_mem_valid        (oMemValid),
        .o_mem_is_branch    (oMemBranch),
        .o_mem_re           (oMemRe),
        .o_mem_we           (oMemWe),
        .o_mem_rd           (oMemRd),
        .o_wb_reg_wr_en     (oWbWr),
        .o_wb_is_mem_to_reg (oWbM2r),
        .o_wb_rd            (oWbRd),
        .o_stall_cnt        (oCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cpu_ctrl_t mkCtrl(bit jal, aluctrl_t op, alusrc_t src, bit br, bit re,
                                         bit we, bit wr, bit m2r);
        cpu_ctrl_t c;
        c.q2_bits          = jal;
        c.q3.aluop         = op;
        c.q3.alusrc        = src;
        c.q4.is_branch     = br;
        c.q4.mem_re        = re;
        c.q4.mem_we        = we;
        c.q5.reg_wr_en     = wr;
        c.q5.is_mem_to_reg = m2r;
        return c;
    endfunction

    function automatic cpu_ctrl_t randCtrl();
        return mkCtrl($urandom_range(0, 7) == 0, aluctrl_t'($urandom_range(0, 7)),
                      alusrc_t'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input cpu_ctrl_t c, input logic [AW-1:0] s1,
                                 input logic [AW-1:0] s2, input logic [AW-1:0] d,
                                 input bit tk, input bit jr);
        idValid = v;
        idCtrl  = c;
        rs1     = s1;
        rs2     = s2;
        rd      = d;
        taken   = tk;
        jalr    = jr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Hazard / redirect decisions taken straight from the instruction-level rules.
    task automatic modelComb();
        bit hazard;
        mRedirect = mMem.valid && ((mMem.ctrl.q4.is_branch && taken) || jalr);
        hazard    = idValid && mEx.valid && mEx.ctrl.q4.mem_re && (mEx.rd != 0)
                    && ((mEx.rd == rs1) || (mEx.rd == rs2));
        mStall    = hazard && !mRedirect;
        mJal      = idValid && idCtrl.q2_bits && !mStall && !mRedirect;
    endtask

    task automatic modelAdvance();
        instr_t none;
        none = '{valid: 1'b0, ctrl: '0, rd: '0};
        modelComb();
        if (rst) begin
            mEx = none; mMem = none; mWb = none; mCnt = 0;
        end else begin
            mWb  = mMem;
            mMem = mRedirect ? none : mEx;
            if (idValid && !mStall && !mRedirect)
                mEx = '{valid: 1'b1, ctrl: idCtrl, rd: rd};
            else
                mEx = none;
            if (mStall && mCnt < (2 ** PW) - 1) mCnt++;
        end
    endtask

    task automatic checkOutput();
        modelComb();
        checkVal("stall", oStall, mStall);
        checkVal("flush_ifid", oFlush, mRedirect || mJal);
        checkVal("id_jal", oJal, mJal);
        checkVal("ex_valid", oExValid, mEx.valid);
        checkVal("ex_aluop", oExAluop, mEx.valid ? mEx.ctrl.q3.aluop : ALUOP_ADD);
        checkVal("ex_alusrc", oExAlusrc, mEx.valid ? mEx.ctrl.q3.alusrc : ALUSRC_IMM);
        checkVal("ex_rd", oExRd, mEx.valid ? mEx.rd : 0);
        checkVal("mem_valid", oMemValid, mMem.valid);
        checkVal("mem_is_branch", oMemBranch, mMem.valid && mMem.ctrl.q4.is_branch);
        checkVal("mem_re", oMemRe, mMem.valid && mMem.ctrl.q4.mem_re);
        checkVal("mem_we", oMemWe, mMem.valid && mMem.ctrl.q4.mem_we);
        checkVal("mem_rd", oMemRd, mMem.valid ? mMem.rd : 0);
        checkVal("wb_reg_wr_en", oWbWr, mWb.valid && mWb.ctrl.q5.reg_wr_en);
        checkVal("wb_mem_to_reg", oWbM2r, mWb.valid && mWb.ctrl.q5.is_mem_to_reg);
        checkVal("wb_rd", oWbRd, mWb.valid ? mWb.rd : 0);
        checkVal("stall_cnt", oCnt, mCnt);
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    initial begin
        cpu_ctrl_t loadC, rtypeC, branchC, jalC, storeC;
        loadC   = mkCtrl(0, ALUOP_ADD, ALUSRC_IMM, 0, 1, 0, 1, 1);
        rtypeC  = mkCtrl(0, ALUOP_ADD, ALUSRC_REG, 0, 0, 0, 1, 0);
        branchC = mkCtrl(0, ALUOP_SUB, ALUSRC_REG, 1, 0, 0, 0, 0);
        jalC    = mkCtrl(1, ALUOP_ADD, ALUSRC_IMM, 0, 0, 0, 1, 0);
        storeC  = mkCtrl(0, ALUOP_ADD, ALUSRC_IMM, 0, 0, 1, 0, 0);

        mEx  = '{valid: 1'b0, ctrl: '0, rd: '0};
        mMem = mEx;
        mWb  = mEx;
        mCnt = 0;

        rst = 1'b1;
        idle();
        #1;
        tick();
        tick();
        checkVal("rst_ex_valid", oExValid, 0);
        checkVal("rst_aluop", oExAluop, ALUOP_ADD);
        checkVal("rst_alusrc", oExAlusrc, ALUSRC_IMM);
        checkVal("rst_mem_valid", oMemValid, 0);
        checkVal("rst_wb_rd", oWbRd, 0);
        checkVal("rst_cnt", oCnt, 0);
        rst = 1'b0;

        // Straight-line flow of one R-type.
        applyStimulus(1, rtypeC, 5'd1, 5'd2, 5'd7, 0, 0);
        tick();
        idle();
        checkVal("flow_c1_alusrc", oExAlusrc, ALUSRC_REG);
        checkVal("flow_c1_rd", oExRd, 7);
        tick();
        checkVal("flow_c2_mem_re", oMemRe, 0);
        checkVal("flow_c2_mem_valid", oMemValid, 1);
        tick();
        checkVal("flow_c3_wb_wr", oWbWr, 1);
        checkVal("flow_c3_wb_rd", oWbRd, 7);

        // Load-use: exactly one stall, bubble into EX.
        applyStimulus(1, loadC, 5'd0, 5'd0, 5'd5, 0, 0);
        tick();
        applyStimulus(1, rtypeC, 5'd5, 5'd3, 5'd6, 0, 0);
        #1;
        checkVal("lu_stall", oStall, 1);
        tick();
        #1;
        checkVal("lu_stall_once", oStall, 0);
        checkVal("lu_ex_bubble", oExValid, 0);
        checkVal("lu_cnt", oCnt, 1);
        tick();
        idle();
        checkVal("lu_add_in_ex", oExRd, 6);
        tick();

        // rd = 0 load and store in EX must not stall.
        applyStimulus(1, loadC, 5'd0, 5'd0, 5'd0, 0, 0);
        tick();
        applyStimulus(1, rtypeC, 5'd0, 5'd0, 5'd6, 0, 0);
        #1;
        checkVal("rd0_no_stall", oStall, 0);
        tick();
        applyStimulus(1, storeC, 5'd1, 5'd2, 5'd5, 0, 0);
        tick();
        applyStimulus(1, rtypeC, 5'd5, 5'd5, 5'd6, 0, 0);
        #1;
        checkVal("store_no_stall", oStall, 0);
        tick();
        idle();
        tick();
        tick();
        tick();

        // Taken branch in MEM coincident with a load-use hazard.
        applyStimulus(1, branchC, 5'd1, 5'd2, 5'd3, 0, 0);
        tick();
        applyStimulus(1, loadC, 5'd1, 5'd0, 5'd9, 0, 0);
        tick();
        applyStimulus(1, rtypeC, 5'd0, 5'd9, 5'd4, 1, 0);
        #1;
        checkVal("redir_stall", oStall, 0);
        checkVal("redir_flush", oFlush, 1);
        tick();
        idle();
        checkVal("redir_ex_squash", oExValid, 0);
        checkVal("redir_mem_squash", oMemValid, 0);
        checkVal("redir_wb_rd", oWbRd, 3);
        checkVal("redir_wb_wr", oWbWr, 0);
        checkVal("redir_cnt", oCnt, 1);
        tick();

        // JAL redirects from ID but still writes its link register.
        applyStimulus(1, jalC, 5'd0, 5'd0, 5'd1, 0, 0);
        #1;
        checkVal("jal_flag", oJal, 1);
        checkVal("jal_flush", oFlush, 1);
        tick();
        idle();
        tick();
        tick();
        checkVal("jal_wb_wr", oWbWr, 1);
        checkVal("jal_wb_rd", oWbRd, 1);

        // Reset with a load in MEM.
        applyStimulus(1, loadC, 5'd0, 5'd0, 5'd4, 0, 0);
        tick();
        idle();
        tick();
        checkVal("mrst_pre_mem_re", oMemRe, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkVal("mrst_ex_valid", oExValid, 0);
        checkVal("mrst_mem_valid", oMemValid, 0);
        checkVal("mrst_cnt", oCnt, 0);
        checkVal("mrst_wb_wr", oWbWr, 0);
        tick();
        checkVal("mrst_wb_wr_next", oWbWr, 0);

        // Five load-use pairs against a 2-bit counter.
        for (int p = 0; p < 5; p++) begin
            applyStimulus(1, loadC, 5'd0, 5'd0, 5'd5, 0, 0);
            tick();
            applyStimulus(1, rtypeC, 5'd5, 5'd0, 5'd6, 0, 0);
            tick();
            tick();
            if (p == 2) checkVal("sat_cnt_after3", oCnt, 3);
        end
        idle();
        tick();
        checkVal("sat_cnt_final", oCnt, 3);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            applyStimulus($urandom_range(0, 3) != 0, randCtrl(),
                          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                          AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
